// File: rtl/reset_sequencer.sv
// reset_sequencer: merges board reset, lock loss and reset request, then releases stage resets in order
`timescale 1ns/100ps
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int STAGES      = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lock,
    input  logic              i_req,
    output logic [STAGES-1:0] o_rst_stage,
    output logic              o_done
);
    localparam int MAXC = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = STAGES > 1 ? $clog2(STAGES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(STAGES - 1);
    typedef enum logic [1:0] {S_HOLD, S_STRETCH, S_RELEASE, S_RUN} state_t;
    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [STAGES-1:0] stage_n;
    logic              done_n;
    logic              lock_meta, lock_s, req_meta, req_s;
    logic              cause;
    assign cause = req_s | ~lock_s;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            req_meta    <= 1'b0;
            req_s       <= 1'b0;
            state       <= S_HOLD;
            cnt         <= '0;
            idx         <= '0;
            o_rst_stage <= '1;
            o_done      <= 1'b0;
        end else begin
            lock_meta   <= i_lock;
            lock_s      <= lock_meta;
            req_meta    <= i_req;
            req_s       <= req_meta;
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            o_rst_stage <= stage_n;
            o_done      <= done_n;
        end
    end
    // stages release lowest-first, so clearing the next one is a left shift with zero fill
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        stage_n = o_rst_stage;
        done_n  = o_done;
        case (state)
            S_HOLD: begin
                stage_n = '1;
                done_n  = 1'b0;
                cnt_n   = '0;
                if (!cause) state_n = S_STRETCH;
            end
            S_STRETCH: begin
                if (cause) begin
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_n = S_RELEASE;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            S_RELEASE: begin
                if (cause) begin
                    state_n = S_HOLD;
                    stage_n = '1;
                    done_n  = 1'b0;
                    cnt_n   = '0;
                end else if (cnt == GAP_LAST) begin
                    stage_n = o_rst_stage << 1;
                    cnt_n   = '0;
                    idx_n   = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_n = S_RUN;
                        done_n  = 1'b1;
                    end
                end else cnt_n = cnt + 1'b1;
            end
            default: begin
                if (cause) begin
                    state_n = S_HOLD;
                    stage_n = '1;
                    done_n  = 1'b0;
                    cnt_n   = '0;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed release-timing checks for default and minimal configurations
`timescale 1ns/100ps
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst, lock, req;
    logic [2:0] o_rst_stage;
    logic       o_done;
    logic [0:0] o_rst_stage2;
    logic       o_done2;
    int vecs = 0;
    int errs = 0;
    int e = 0;
    always #5 clk = ~clk;
    reset_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_lock(lock), .i_req(req),
        .o_rst_stage(o_rst_stage), .o_done(o_done)
    );
    reset_sequencer #(.HOLD_CYCLES(2), .STAGE_GAP(1), .STAGES(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_lock(lock), .i_req(req),
        .o_rst_stage(o_rst_stage2), .o_done(o_done2)
    );
    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask
    task automatic go(input int k);
        while (e < k) tick();
    endtask
    task automatic chk(input string tag, input logic [2:0] s, input logic d);
        vecs++;
        assert (o_rst_stage === s && o_done === d) else begin
            errs++;
            $error("FAIL %s edge %0d: got stage=%b done=%b, want stage=%b done=%b", tag, e, o_rst_stage, o_done, s, d);
        end
    endtask
    task automatic chk2(input string tag, input logic s, input logic d);
        vecs++;
        assert (o_rst_stage2 === s && o_done2 === d) else begin
            errs++;
            $error("FAIL %s edge %0d: got stage=%b done=%b, want stage=%b done=%b", tag, e, o_rst_stage2, o_done2, s, d);
        end
    endtask
    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        e = 0;
    endtask
    initial begin
        rst = 1'b1; lock = 1'b1; req = 1'b0;
        #2;
        chk("reset_state", 3'b111, 1'b0);
        chk2("reset_state2", 1'b1, 1'b0);
        repeat (2) tick();
        chk("reset_held", 3'b111, 1'b0);
        rst = 1'b0;
        e = 0;
        go(5);  chk2("min_edge5", 1'b1, 1'b0);
        go(6);  chk2("min_edge6", 1'b0, 1'b1);
        go(22); chk("pwr_e22", 3'b111, 1'b0);
        go(23); chk("pwr_e23", 3'b110, 1'b0);
        go(26); chk("pwr_e26", 3'b110, 1'b0);
        go(27); chk("pwr_e27", 3'b100, 1'b0);
        go(30); chk("pwr_e30", 3'b100, 1'b0);
        go(31); chk("pwr_e31", 3'b000, 1'b1);
        go(40); chk("run_e40", 3'b000, 1'b1);
        #2.1;
        rst = 1'b1;
        #0.2;
        chk("async_rst", 3'b111, 1'b0);
        chk2("async_rst2", 1'b1, 1'b0);
        #3;
        rst = 1'b0;
        e = 0;
        go(22); chk("rerun_e22", 3'b111, 1'b0);
        go(23); chk("rerun_e23", 3'b110, 1'b0);
        go(31); chk("rerun_e31", 3'b000, 1'b1);
        pulse_rst();
        go(10); req = 1'b1;
        go(12); req = 1'b0;
        go(23); chk("req_no_early", 3'b111, 1'b0);
        go(34); chk("req_e34", 3'b111, 1'b0);
        go(35); chk("req_e35", 3'b110, 1'b0);
        go(39); chk("req_e39", 3'b100, 1'b0);
        go(42); chk("req_e42", 3'b100, 1'b0);
        go(43); chk("req_e43", 3'b000, 1'b1);
        pulse_rst();
        go(23); chk("lock_pre", 3'b110, 1'b0);
        go(24); lock = 1'b0;
        go(26); chk("lock_e26", 3'b110, 1'b0);
        go(27); chk("lock_e27", 3'b111, 1'b0);
        lock = 1'b1;
        go(49); chk("lock_e49", 3'b111, 1'b0);
        go(50); chk("lock_e50", 3'b110, 1'b0);
        go(54); chk("lock_e54", 3'b100, 1'b0);
        go(57); chk("lock_e57", 3'b100, 1'b0);
        go(58); chk("lock_e58", 3'b000, 1'b1);
        req = 1'b1;
        e = 0;
        go(2); chk("req_hold_e2", 3'b000, 1'b1);
        go(3); chk("req_hold_e3", 3'b111, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("req_stuck", 3'b111, 1'b0);
        end
        chk2("req_stuck2", 1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
